// File: rtl/f1_pkg.sv
// f1_pkg: shared state type and sizing constants for the F1 start-light reaction game
package f1_pkg;
  typedef enum logic [2:0] {IDLE, ARMED, TIMING, DONE, FALSE_START} rt_state_t;
  localparam int MAX_MS_DEFAULT = 9999;
  localparam int RT_W = 14;
endpackage

// File: rtl/edge_sync.sv
// edge_sync: two-flop synchroniser followed by a single-cycle rising-edge pulse
module edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic pulse
);
  logic [2:0] sr;
  // sr[1:0] synchronise the raw input, sr[2] remembers the previous synchronised level
  always_ff @(posedge clk or negedge rst)
    if (!rst) sr <= '0;
    else sr <= {sr[1:0], d};
  assign pulse = sr[1] & ~sr[2];
endmodule

// File: rtl/reaction_timer.sv
// reaction_timer: times the driver's button press after lights-out, tracks best time and jump starts
module reaction_timer
  import f1_pkg::*;
#(
  parameter int W = RT_W,
  parameter int MAX_MS = MAX_MS_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         tick_ms,
  input  logic         arm,
  input  logic         lights_out,
  input  logic         react_btn,
  input  logic         clear_best,
  output logic [W-1:0] rt_ms,
  output logic         rt_valid,
  output logic         jump_start,
  output logic         timeout,
  output logic [W-1:0] best_ms,
  output logic         busy
);
  localparam logic [W-1:0] MAX = W'(MAX_MS);
  if (2 ** W <= MAX_MS) begin : g_width_check
    $error("reaction_timer: W too narrow to hold MAX_MS");
  end
  rt_state_t state, state_nx;
  logic [W-1:0] cnt, cnt_nx, rt_nx, best_nx;
  logic valid_nx, js_nx, to_nx, press;
  edge_sync u_btn (.clk(clk), .rst(rst), .d(react_btn), .pulse(press));
  // next state and next registered outputs; arm overrides everything, a press beats lights_out and the timeout
  always_comb begin
    state_nx = state;
    cnt_nx = cnt;
    rt_nx = rt_ms;
    valid_nx = 1'b0;
    js_nx = jump_start;
    to_nx = timeout;
    best_nx = clear_best ? MAX : best_ms;
    if (arm) begin
      state_nx = ARMED;
      cnt_nx = '0;
      js_nx = 1'b0;
      to_nx = 1'b0;
    end else if (state == ARMED && press) begin
      state_nx = FALSE_START;
      js_nx = 1'b1;
    end else if (state == ARMED && lights_out) begin
      state_nx = TIMING;
      cnt_nx = '0;
    end else if (state == TIMING && press) begin
      state_nx = DONE;
      rt_nx = cnt;
      valid_nx = 1'b1;
      if (cnt < best_ms) best_nx = cnt;
    end else if (state == TIMING && cnt == MAX) begin
      state_nx = DONE;
      rt_nx = MAX;
      to_nx = 1'b1;
      valid_nx = 1'b1;
    end else if (state == TIMING && tick_ms) begin
      cnt_nx = cnt + W'(1);
    end
  end
  // state, counter and all registered outputs
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      cnt <= '0;
      rt_ms <= '0;
      rt_valid <= 1'b0;
      jump_start <= 1'b0;
      timeout <= 1'b0;
      best_ms <= MAX;
    end else begin
      state <= state_nx;
      cnt <= cnt_nx;
      rt_ms <= rt_nx;
      rt_valid <= valid_nx;
      jump_start <= js_nx;
      timeout <= to_nx;
      best_ms <= best_nx;
    end
  assign busy = (state == ARMED) || (state == TIMING);
endmodule

// File: tb/tb_reaction_timer.sv
// tb_reaction_timer: randomized runs checked against a run-level model of reaction time and best time
module tb_reaction_timer;
  import f1_pkg::*;
  localparam int W = RT_W;
  localparam int MX = MAX_MS_DEFAULT;
  logic clk = 0, rst = 0, tick_ms = 0, arm = 0, lights_out = 0, react_btn = 0, clear_best = 0;
  logic [W-1:0] rt_ms, best_ms;
  logic rt_valid, jump_start, timeout, busy;
  int checks = 0, errors = 0, vcnt = 0;
  int exp_rt = 0, exp_best = MX;
  reaction_timer dut (
    .clk(clk), .rst(rst), .tick_ms(tick_ms), .arm(arm), .lights_out(lights_out),
    .react_btn(react_btn), .clear_best(clear_best), .rt_ms(rt_ms), .rt_valid(rt_valid),
    .jump_start(jump_start), .timeout(timeout), .best_ms(best_ms), .busy(busy)
  );
  always #5 clk = ~clk;
  // count rt_valid pulses, sampled mid-cycle
  always @(negedge clk) if (rt_valid) vcnt++;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask
  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic pulse_arm();
    arm = 1;
    step();
    arm = 0;
  endtask
  task automatic pulse_lights();
    lights_out = 1;
    step();
    lights_out = 0;
  endtask
  task automatic ticks(input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      tick_ms = 1;
      step();
      tick_ms = 0;
      if (gap > 0) step($urandom_range(0, gap));
    end
  endtask
  task automatic press(input bit clr = 0);
    react_btn = 1;
    step(2);
    clear_best = clr;
    step();
    clear_best = 0;
    step($urandom_range(0, 3));
    react_btn = 0;
    step(3);
  endtask
  task automatic expect_all(input string tag, input int v_exp, input bit js, input bit to);
    chk({tag, ".rt_ms"}, rt_ms, exp_rt);
    chk({tag, ".best_ms"}, best_ms, exp_best);
    chk({tag, ".jump_start"}, jump_start, js);
    chk({tag, ".timeout"}, timeout, to);
    chk({tag, ".busy"}, busy, 0);
    chk({tag, ".valid_pulses"}, vcnt, v_exp);
  endtask
  task automatic valid_run(input string tag, input int n, input bit clr = 0);
    int v0;
    v0 = vcnt;
    pulse_arm();
    step($urandom_range(0, 3));
    chk({tag, ".busy_armed"}, busy, 1);
    pulse_lights();
    ticks(n, 2);
    press(clr);
    exp_rt = n;
    if (n < exp_best) exp_best = n;
    else if (clr) exp_best = MX;
    expect_all(tag, v0 + 1, 0, 0);
  endtask
  task automatic do_clear(input string tag);
    clear_best = 1;
    step();
    clear_best = 0;
    exp_best = MX;
    chk(tag, best_ms, exp_best);
  endtask
  initial begin
    int v0, n;
    step(3);
    expect_all("reset", 0, 0, 0);
    chk("reset.rt_valid", rt_valid, 0);
    rst = 1;
    step(2);
    valid_run("nominal", 10);
    do_clear("clear0");
    valid_run("best250", 250);
    valid_run("best180", 180);
    valid_run("best300", 300);
    do_clear("clear1");
    valid_run("best400", 400);
    valid_run("clr_vs_update", 120, 1);
    valid_run("clr_no_update", 700, 1);
    // jump start, then a late lights_out and press must be ignored
    v0 = vcnt;
    pulse_arm();
    step(2);
    press();
    expect_all("jump", v0, 1, 0);
    pulse_lights();
    ticks(5, 0);
    press();
    expect_all("jump_hold", v0, 1, 0);
    // press and lights_out on the same edge
    pulse_arm();
    react_btn = 1;
    step(2);
    lights_out = 1;
    step();
    lights_out = 0;
    react_btn = 0;
    step(3);
    expect_all("press_lights", v0, 1, 0);
    // press coinciding with a tick at counter 57
    v0 = vcnt;
    pulse_arm();
    pulse_lights();
    ticks(57, 0);
    react_btn = 1;
    step(2);
    tick_ms = 1;
    step();
    tick_ms = 0;
    react_btn = 0;
    step(3);
    exp_rt = 57;
    if (57 < exp_best) exp_best = 57;
    expect_all("tick57", v0 + 1, 0, 0);
    // press coinciding with the saturating tick
    do_clear("clear2");
    v0 = vcnt;
    pulse_arm();
    pulse_lights();
    ticks(MX - 1, 0);
    react_btn = 1;
    step(2);
    tick_ms = 1;
    step();
    tick_ms = 0;
    react_btn = 0;
    step(3);
    exp_rt = MX - 1;
    exp_best = MX - 1;
    expect_all("sat_press", v0 + 1, 0, 0);
    // timeout with no press, then a late press is ignored
    valid_run("pre_timeout", 333);
    v0 = vcnt;
    pulse_arm();
    pulse_lights();
    ticks(MX, 0);
    step(2);
    exp_rt = MX;
    expect_all("timeout", v0 + 1, 0, 1);
    press();
    expect_all("timeout_hold", v0 + 1, 0, 1);
    // randomized runs, some jump starts and clears mixed in
    for (int r = 0; r < 8; r++) begin
      if ($urandom_range(0, 4) == 0) do_clear("rnd_clear");
      if ($urandom_range(0, 3) == 0) begin
        v0 = vcnt;
        pulse_arm();
        step($urandom_range(0, 4));
        press();
        expect_all("rnd_jump", v0, 1, 0);
      end else begin
        n = $urandom_range(1, 600);
        valid_run("rnd_run", n);
      end
    end
    // asynchronous reset in the middle of timing
    pulse_arm();
    pulse_lights();
    ticks(500, 0);
    #3;
    rst = 0;
    #1;
    exp_rt = 0;
    exp_best = MX;
    chk("midrst.rt_valid", rt_valid, 0);
    expect_all("midrst", vcnt, 0, 0);
    step(2);
    rst = 1;
    v0 = vcnt;
    pulse_lights();
    press();
    expect_all("post_rst", v0, 0, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/reaction_timer.md
Name: reaction_timer

Overview:
- Measures driver reaction time after lights-out, downstream of the light-sequence FSM and the random-delay block.
- Armed by the FSM's start pulse; starts timing on the delay block's lights-out pulse; stops on the driver's button press.
- Produces a saturating millisecond result, a best-time register and a jump-start flag.
- rt_ms and best_ms are binary outputs sized for the 16-bit binary-to-BCD converter and 7-seg display path.

Parameters:
- W, 14, width of the millisecond counter and result (max 16383).
- MAX_MS, 9999, saturation and timeout value in ms (4-digit display limit).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  asynchronous, active-low reset.
- tick_ms  input  1  one-cycle enable pulse every 1 ms.
- arm  input  1  one-cycle pulse; the light sequence has started.
- lights_out  input  1  one-cycle pulse; the random delay has expired.
- react_btn  input  1  raw driver button, active-high level (board drives ~KEY), asynchronous.
- clear_best  input  1  one-cycle pulse; resets the best-time register.
- rt_ms  output  W  last reaction time in ms.
- rt_valid  output  1  one-cycle pulse when rt_ms updates.
- jump_start  output  1  level; button pressed before lights-out.
- timeout  output  1  level; no press within MAX_MS.
- best_ms  output  W  lowest valid rt_ms since reset or clear_best.
- busy  output  1  high in ARMED or TIMING.

Behaviour:
- Reset (rst=0, async): state=IDLE, rt_ms=0, rt_valid=0, jump_start=0, timeout=0, best_ms=MAX_MS, counter=0, synchroniser flops=0.
- react_btn path: 2-flop synchroniser, then rising-edge detect giving press, a one-cycle pulse. Press latency is 3 clk from the input edge. A held button gives only one press.
- States: IDLE, ARMED, TIMING, DONE, FALSE_START.
- arm in any state:
  - go to ARMED; clear jump_start and timeout; counter=0.
  - rt_ms and best_ms are held.
- ARMED:
  - press -> FALSE_START and set jump_start=1.
  - Otherwise, lights_out -> TIMING with counter=0.
  - press and lights_out in the same cycle -> FALSE_START (jump start wins).
- TIMING:
  - On tick_ms, counter increments by 1, saturating at MAX_MS.
  - press -> DONE; rt_ms=counter value before any same-cycle increment; rt_valid=1 for exactly the next cycle.
  - If counter==MAX_MS, then at that same clock edge: rt_ms=MAX_MS, timeout=1, rt_valid pulses, -> DONE.
  - press and the saturating tick in the same cycle count as a valid press with rt_ms=MAX_MS-1.
- best_ms update: on a valid press (not timeout) where counter < best_ms, best_ms=counter on the same edge as rt_ms. Equal values do not update. Timeouts and jump starts never update best_ms.
- clear_best: sets best_ms=MAX_MS. If it coincides with a best update, the update wins.
- DONE and FALSE_START are held until arm. lights_out and press are ignored in IDLE, DONE and FALSE_START.
- busy = (state==ARMED) or (state==TIMING), decoded combinationally from the state register.
- All outputs are registered except busy.
- Width rule: W must satisfy 2^W > MAX_MS. Checked by an elaboration-time assertion.

Decomposition:
- Shared package f1_pkg:
  - typedef enum logic [2:0] rt_state_t {IDLE, ARMED, TIMING, DONE, FALSE_START}.
  - localparam MAX_MS_DEFAULT=9999.
  - localparam RT_W=14.
- One sub-module, edge_sync: 2-flop synchroniser plus rising-edge pulse, same clk/rst. Reusable for the KEY inputs elsewhere.

Test Plan:
- Nominal: arm, lights_out, 10 tick_ms, then react_btn high -> after the press, rt_ms=10, one rt_valid pulse, best_ms=10, jump_start=0, timeout=0.
- Jump start: arm, react_btn high before lights_out -> jump_start=1, state FALSE_START, no rt_valid, rt_ms and best_ms unchanged. A later lights_out is ignored.
- Timeout: arm, lights_out, 9999 ticks with no press -> rt_ms=9999, timeout=1, one rt_valid pulse, best_ms unchanged. A press afterwards is ignored.
- Best tracking: runs of 250, 180, 300 ms -> best_ms 250, then 180, then 180. clear_best -> 9999. Next run of 400 -> best_ms=400.
- Simultaneous events: press and lights_out in the same cycle -> FALSE_START. In TIMING, press coinciding with a tick at counter=57 -> rt_ms=57.
- Reset mid-run: assert rst=0 in TIMING at counter=500 -> all outputs reach reset values immediately (async). After release, press is ignored until arm.
